// File: rtl/demux8_defs.sv
// Shared definitions for the 8-slot TDM receiver: FSM encodings and frame geometry.
package demux8_defs;
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_t;

  localparam logic [2:0] SLOT_LAST = 3'd7;
endpackage

// File: rtl/dec3to8.sv
// Combinational 3-to-8 one-hot decoder; selects which shadow bit the current slot writes.
module dec3to8 (
  input  logic [2:0] i_sel,
  output logic [7:0] o_onehot
);
  always_comb begin
    o_onehot        = 8'b0;
    o_onehot[i_sel] = 1'b1;
  end
endmodule

// File: rtl/demux8_tdm.sv
// 1:8 TDM demultiplexer: one bit per enabled cycle into an 8-bit frame, published with a valid pulse.
// DEMUX8_TDM_SYNC_CHECK_EN adds HUNT/LOCK alignment to the sync marker and the err pulse.
module demux8_tdm
  import demux8_defs::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_din,
  input  logic i_sync,
  output logic o_q0,
  output logic o_q1,
  output logic o_q2,
  output logic o_q3,
  output logic o_q4,
  output logic o_q5,
  output logic o_q6,
  output logic o_q7,
  output logic o_valid,
  output logic o_s0,
  output logic o_s1,
  output logic o_s2,
  output logic o_err
);
  logic [2:0] r_slot;
  logic [6:0] r_shadow;
  logic [7:0] r_q;
  logic       r_valid;
  logic [7:0] w_wr;

  dec3to8 u_dec (
    .i_sel    (r_slot),
    .o_onehot (w_wr)
  );

`ifdef DEMUX8_TDM_SYNC_CHECK_EN
  state_t r_state;
  logic   r_err;
`else
  logic   w_unused_sync;
  assign w_unused_sync = i_sync;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slot   <= 3'd0;
      r_shadow <= 7'd0;
      r_q      <= 8'd0;
      r_valid  <= 1'b0;
`ifdef DEMUX8_TDM_SYNC_CHECK_EN
      r_state  <= ST_HUNT;
      r_err    <= 1'b0;
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef DEMUX8_TDM_SYNC_CHECK_EN
      r_err   <= 1'b0;
`endif
      if (i_en) begin
`ifdef DEMUX8_TDM_SYNC_CHECK_EN
        // A marker always restarts the frame at slot 0; mid-frame it also drops the partial frame.
        if (i_sync) begin
          if (r_state == ST_LOCK && r_slot != 3'd0)
            r_err <= 1'b1;
          r_shadow[0] <= i_din;
          r_slot      <= 3'd1;
          r_state     <= ST_LOCK;
        end else if (r_state == ST_LOCK) begin
`else
        begin
`endif
          if (w_wr[SLOT_LAST]) begin
            r_q     <= {i_din, r_shadow};
            r_valid <= 1'b1;
            r_slot  <= 3'd0;
          end else begin
            for (int k = 0; k < 7; k++)
              if (w_wr[k]) r_shadow[k] <= i_din;
            r_slot <= r_slot + 3'd1;
          end
        end
      end
    end
  end

  assign {o_q7, o_q6, o_q5, o_q4, o_q3, o_q2, o_q1, o_q0} = r_q;
  assign {o_s2, o_s1, o_s0} = r_slot;
  assign o_valid = r_valid;
`ifdef DEMUX8_TDM_SYNC_CHECK_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif
endmodule

// File: tb/tb_demux8_tdm.sv
// Scoreboard bench for demux8_tdm; expectations follow DEMUX8_TDM_SYNC_CHECK_EN when defined.
module tb_demux8_tdm;
`ifdef DEMUX8_TDM_SYNC_CHECK_EN
  localparam bit SYNC_CHK = 1'b1;
`else
  localparam bit SYNC_CHK = 1'b0;
`endif

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_en = 1'b0;
  logic i_din = 1'b0;
  logic i_sync = 1'b0;
  logic o_q0, o_q1, o_q2, o_q3, o_q4, o_q5, o_q6, o_q7;
  logic o_valid, o_s0, o_s1, o_s2, o_err;

  demux8_tdm dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_din(i_din), .i_sync(i_sync),
    .o_q0(o_q0), .o_q1(o_q1), .o_q2(o_q2), .o_q3(o_q3),
    .o_q4(o_q4), .o_q5(o_q5), .o_q6(o_q6), .o_q7(o_q7),
    .o_valid(o_valid), .o_s0(o_s0), .o_s1(o_s1), .o_s2(o_s2), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int         cyc;
    logic [7:0] frm;
  } exp_t;

  exp_t frm_q[$];
  int   err_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit run    = 1'b0;

  // Reference state, updated just after each active edge.
  bit         m_lock  = 1'b0;
  logic [2:0] m_slot  = 3'd0;
  logic [7:0] m_shad  = 8'd0;
  logic [7:0] m_q     = 8'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic drive(input logic en, input logic din, input logic sync, input logic rst);
    i_rst = rst; i_en = en; i_din = din; i_sync = sync;
    @(posedge i_clk);
    #1;
    if (rst) begin
      m_lock = !SYNC_CHK; m_slot = 3'd0; m_shad = 8'd0; m_q = 8'd0;
    end else if (en) begin
      if (SYNC_CHK && sync) begin
        if (m_lock && m_slot != 3'd0) err_q.push_back(cyc);
        m_shad[0] = din; m_slot = 3'd1; m_lock = 1'b1;
      end else if (m_lock) begin
        m_shad[m_slot] = din;
        if (m_slot == 3'd7) begin
          m_q = m_shad;
          frm_q.push_back('{cyc: cyc, frm: m_q});
          m_slot = 3'd0;
        end else begin
          m_slot = m_slot + 3'd1;
        end
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] f, input bit with_sync);
    for (int i = 0; i < 8; i++) drive(1'b1, f[i], with_sync && i == 0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge i_clk) begin
    if (run) begin
      check("slot", {29'd0, o_s2, o_s1, o_s0}, {29'd0, m_slot});
      check("q", {24'd0, o_q7, o_q6, o_q5, o_q4, o_q3, o_q2, o_q1, o_q0}, {24'd0, m_q});
      if (o_valid) begin
        if (frm_q.size() == 0) check("valid_unexpected", 32'(o_valid), 32'd0);
        else begin
          check("valid_cycle", cyc, frm_q[0].cyc);
          check("frame", {24'd0, o_q7, o_q6, o_q5, o_q4, o_q3, o_q2, o_q1, o_q0},
                {24'd0, frm_q[0].frm});
          void'(frm_q.pop_front());
        end
      end else if (frm_q.size() != 0 && frm_q[0].cyc <= cyc) begin
        check("valid_missing", 32'(o_valid), 32'd1);
        void'(frm_q.pop_front());
      end
      if (o_err) begin
        if (err_q.size() == 0) check("err_unexpected", 32'(o_err), 32'd0);
        else begin
          check("err_cycle", cyc, err_q[0]);
          void'(err_q.pop_front());
        end
      end else if (err_q.size() != 0 && err_q[0] <= cyc) begin
        check("err_missing", 32'(o_err), 32'd1);
        void'(err_q.pop_front());
      end
    end
  end

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    run = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_err", 32'(o_err), 32'd0);

    // Unaligned ones: ignored while hunting, two all-ones frames when free-running.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    send_frame(8'b0100_1101, 1'b1);
    idle(2);

    send_frame(8'hFF, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(3);

    // Same frame with a 3-cycle gap between slots 3 and 4.
    for (int i = 0; i < 8; i++) begin
      if (i == 4) idle(3);
      drive(1'b1, i inside {0, 2, 3, 6}, i == 0, 1'b0);
    end
    idle(2);

    // Marker re-asserted at slot 5; the next 7 bits complete a frame with q0=1.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, i == 0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(1'b1, i[0], 1'b0, 1'b0);
    idle(2);

    // Reset part-way into a frame, then unaligned traffic.
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b1, i == 0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    check("rst_q", {24'd0, o_q7, o_q6, o_q5, o_q4, o_q3, o_q2, o_q1, o_q0}, 32'd0);
    check("rst_slot", {29'd0, o_s2, o_s1, o_s0}, 32'd0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
    idle(4);

    check("frames_left", frm_q.size(), 0);
    check("errs_left", err_q.size(), 0);
    run = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
